// File: rtl/sort_frame_parser.sv
// ============================================================================
// sort_frame_parser : byte-stream frame parser (SYNC,LEN,payload,XOR) with
// checksum-gated word AXI-stream output.            Revision 1.0
// ============================================================================
`default_nettype none

module sort_frame_parser #(
    parameter int          WORD_BYTES     = 2,
    parameter int          MAX_ELEMS      = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [8*WORD_BYTES-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [7:0]              pkt_len,
    output logic                    err_checksum,
    output logic                    err_length,
    output logic                    err_timeout,
    output logic                    busy
);

    localparam int         IDX_W   = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
    localparam int         BI_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_ELEMS);
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t                  state;
    logic [7:0]              elem_idx;
    logic [BI_W-1:0]         byte_idx;
    logic [7:0]              xor_acc;
    logic [31:0]             tmo_cnt;
    logic [8*WORD_BYTES-1:0] buffer [0:MAX_ELEMS-1];

    logic accept;
    logic tmo_hit;

    assign s_axis_tready = (state != S_DRAIN);
    assign busy          = (state != S_IDLE);
    assign accept        = s_axis_tvalid && s_axis_tready;
    // Fires on the edge where the idle count reaches TIMEOUT_CYCLES.
    assign tmo_hit       = (TIMEOUT_CYCLES != 0) &&
                           ((tmo_cnt + 32'd1) == 32'(TIMEOUT_CYCLES));

    // Packet storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && accept) begin
            buffer[elem_idx[IDX_W-1:0]][8*byte_idx +: 8] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pkt_len       <= 8'd0;
            elem_idx      <= 8'd0;
            byte_idx      <= '0;
            xor_acc       <= 8'd0;
            tmo_cnt       <= 32'd0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err_checksum  <= 1'b0;
            err_length    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;

            case (state)
                S_IDLE: begin
                    tmo_cnt <= 32'd0;
                    if (accept && s_axis_tdata == SYNC_BYTE) begin
                        state <= S_LEN;
                    end
                end

                S_LEN, S_PAYLOAD, S_CHECK: begin
                    if (accept) begin
                        tmo_cnt <= 32'd0;
                        if (state == S_LEN) begin
                            pkt_len <= s_axis_tdata;
                            if (s_axis_tdata == 8'd0 || s_axis_tdata > MAX_LEN) begin
                                err_length <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                elem_idx <= 8'd0;
                                byte_idx <= '0;
                                xor_acc  <= 8'd0;
                                state    <= S_PAYLOAD;
                            end
                        end else if (state == S_PAYLOAD) begin
                            xor_acc <= xor_acc ^ s_axis_tdata;
                            if (byte_idx == LAST_BYTE) begin
                                byte_idx <= '0;
                                elem_idx <= elem_idx + 8'd1;
                                if (elem_idx == pkt_len - 8'd1) begin
                                    state <= S_CHECK;
                                end
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end else begin
                            if (s_axis_tdata != xor_acc) begin
                                err_checksum <= 1'b1;
                                state        <= S_IDLE;
                            end else begin
                                // elem_idx becomes the read pointer for draining.
                                m_axis_tdata  <= buffer[0];
                                m_axis_tvalid <= 1'b1;
                                m_axis_tlast  <= (pkt_len == 8'd1);
                                elem_idx      <= 8'd1;
                                state         <= S_DRAIN;
                            end
                        end
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        tmo_cnt     <= 32'd0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                S_DRAIN: begin
                    tmo_cnt <= 32'd0;
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            state         <= S_IDLE;
                        end else begin
                            m_axis_tdata <= buffer[elem_idx[IDX_W-1:0]];
                            m_axis_tlast <= (elem_idx == pkt_len - 8'd1);
                            elem_idx     <= elem_idx + 8'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sort_frame_parser.sv
// ============================================================================
// tb_sort_frame_parser : directed self-checking bench for sort_frame_parser.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sort_frame_parser;

    localparam int WB   = 2;
    localparam int MAXE = 16;
    localparam int TMO  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [8*WB-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [7:0]    pkt_len;
    logic          err_checksum, err_length, err_timeout, busy;

    always #5 clk = ~clk;

    sort_frame_parser #(
        .WORD_BYTES(WB), .MAX_ELEMS(MAXE), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .pkt_len(pkt_len),
        .err_checksum(err_checksum), .err_length(err_length), .err_timeout(err_timeout),
        .busy(busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]      tx_q[$];
    logic [8*WB-1:0] exp_q[$];
    logic [8*WB-1:0] got_data[$];
    logic            got_last[$];
    int              got_cyc[$];
    int cyc = 0, n_ck = 0, n_len = 0, n_tmo = 0, n_valid = 0;

    // Passive monitor: records handshakes and error pulse cycles.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
                got_cyc.push_back(cyc);
            end
            if (m_tvalid)     n_valid++;
            if (err_checksum) n_ck++;
            if (err_length)   n_len++;
            if (err_timeout)  n_tmo++;
        end
    end

    task automatic clear_mon();
        got_data.delete(); got_last.delete(); got_cyc.delete();
        n_ck = 0; n_len = 0; n_tmo = 0; n_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_tdata  = b;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i]);
    endtask

    task automatic build_pkt(input int len, input int seed);
        logic [7:0]      x;
        logic [7:0]      by;
        logic [8*WB-1:0] w;
        tx_q.delete(); exp_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(len));
        x = 8'h00;
        for (int e = 0; e < len; e++) begin
            w = '0;
            for (int b = 0; b < WB; b++) begin
                by = 8'(seed + 13 * (e * WB + b));
                w[8*b +: 8] = by;
                x = x ^ by;
                tx_q.push_back(by);
            end
            exp_q.push_back(w);
        end
        tx_q.push_back(x);
    endtask

    task automatic wait_words(input int n);
        for (int k = 0; k < 300 && got_data.size() < n; k++) begin
            @(posedge clk); #1;
        end
        idle(3);
    endtask

    task automatic check_words(input string name);
        vectors++;
        if (got_data.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s word_count: got %0d expected %0d", name, got_data.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
                miscompares++;
                $display("FAIL %s word[%0d]: got %h last=%b expected %h last=%b",
                         name, i, got_data[i], got_last[i], exp_q[i], (i == exp_q.size() - 1));
            end
        end
        vectors++;
        if (busy !== 1'b0 || s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_after: busy=%b s_tready=%b m_tvalid=%b expected 0 1 0",
                     name, busy, s_tready, m_tvalid);
        end
    endtask

    task automatic load_std(input logic [7:0] chk);
        tx_q  = '{8'hA5, 8'h03, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, chk};
        exp_q = '{16'h1234, 16'h5678, 16'h9ABC};
    endtask

    task automatic run_std_packet(input string name);
        clear_mon();
        m_tready = 1'b1;
        load_std(8'h2E);
        send_frame();
        vectors++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL %s first_latency: tvalid=%b tdata=%h expected 1 1234", name, m_tvalid, m_tdata);
        end
        wait_words(3);
        check_words(name);
        vectors++;
        if (pkt_len !== 8'd3 || (n_ck + n_len + n_tmo) != 0) begin
            miscompares++;
            $display("FAIL %s len_err: pkt_len=%0d errs=%0d expected 3 0", name, pkt_len, n_ck + n_len + n_tmo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
        idle(2);
        vectors++;
        if ({s_tready, m_tvalid, m_tlast, m_tdata, pkt_len, err_checksum, err_length, err_timeout, busy}
            !== {1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: tready=%b tvalid=%b tlast=%b tdata=%h len=%h err=%b%b%b busy=%b",
                     s_tready, m_tvalid, m_tlast, m_tdata, pkt_len, err_checksum, err_length, err_timeout, busy);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_packet();
        run_std_packet("good");
        vectors++;
        if (got_cyc.size() == 3 && (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1)) begin
            miscompares++;
            $display("FAIL good_consecutive: cycles %0d %0d %0d expected consecutive",
                     got_cyc[0], got_cyc[1], got_cyc[2]);
        end
    endtask

    task automatic test_bad_checksum();
        clear_mon();
        m_tready = 1'b1;
        load_std(8'h2F);
        send_frame();
        idle(5);
        vectors++;
        if (n_ck != 1 || n_valid != 0 || busy !== 1'b0 || n_len + n_tmo != 0) begin
            miscompares++;
            $display("FAIL bad_checksum: ck_cycles=%0d tvalid_cycles=%0d busy=%b expected 1 0 0",
                     n_ck, n_valid, busy);
        end
        run_std_packet("after_bad_ck");
    endtask

    task automatic test_length_errors();
        clear_mon();
        send_byte(8'hA5); send_byte(8'h00);
        idle(3);
        vectors++;
        if (n_len != 1 || busy !== 1'b0 || n_valid != 0) begin
            miscompares++;
            $display("FAIL len_zero: len_cycles=%0d busy=%b tvalid_cycles=%0d expected 1 0 0", n_len, busy, n_valid);
        end
        clear_mon();
        send_byte(8'hA5); send_byte(8'h11);
        idle(3);
        vectors++;
        if (n_len != 1 || busy !== 1'b0 || n_valid != 0) begin
            miscompares++;
            $display("FAIL len_17: len_cycles=%0d busy=%b tvalid_cycles=%0d expected 1 0 0", n_len, busy, n_valid);
        end
        clear_mon();
        m_tready = 1'b1;
        build_pkt(16, 7);
        send_frame();
        wait_words(16);
        check_words("len_16");
        vectors++;
        if (pkt_len !== 8'd16 || n_ck + n_len + n_tmo != 0) begin
            miscompares++;
            $display("FAIL len_16_meta: pkt_len=%0d errs=%0d expected 16 0", pkt_len, n_ck + n_len + n_tmo);
        end
    endtask

    task automatic test_timeout();
        int fire_at;
        logic busy_before;
        clear_mon();
        fire_at = -1;
        busy_before = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h34);
        for (int n = 1; n <= 150; n++) begin
            @(posedge clk); #1;
            if (n == TMO - 1) busy_before = busy;
            if (err_timeout === 1'b1 && fire_at < 0) fire_at = n;
        end
        vectors++;
        if (fire_at != TMO || n_tmo != 1) begin
            miscompares++;
            $display("FAIL timeout_cycle: fired at %0d (pulse cycles %0d) expected %0d (1)", fire_at, n_tmo, TMO);
        end
        vectors++;
        if (busy_before !== 1'b1 || busy !== 1'b0 || n_ck + n_len != 0) begin
            miscompares++;
            $display("FAIL timeout_busy: before=%b after=%b expected 1 0", busy_before, busy);
        end
        run_std_packet("after_timeout");
    endtask

    task automatic test_backpressure();
        logic pv, pl, pr;
        logic [8*WB-1:0] pd;
        clear_mon();
        m_tready = 1'b0;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        build_pkt(6, 91);
        send_frame();
        for (int k = 0; k < 300 && got_data.size() < 6; k++) begin
            pv = m_tvalid; pd = m_tdata; pl = m_tlast;
            m_tready = (k == 0) ? 1'b0 : 1'(($urandom_range(0, 2)) != 0 ? 1 : 0) & 1'($urandom_range(0, 1));
            pr = m_tready;
            if (m_tvalid === 1'b1) begin
                vectors++;
                if (s_tready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_s_tready: got %b expected 0 during drain", s_tready);
                end
            end
            @(posedge clk); #1;
            if (pv && !pr) begin
                vectors++;
                if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
                    miscompares++;
                    $display("FAIL bp_stall_stable: tvalid=%b tdata=%h tlast=%b expected 1 %h %b",
                             m_tvalid, m_tdata, m_tlast, pd, pl);
                end
            end
        end
        m_tready = 1'b1;
        idle(3);
        check_words("backpressure");
    endtask

    task automatic test_reset_midop();
        clear_mon();
        m_tready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h34); send_byte(8'h12);
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || s_tready !== 1'b1 || pkt_len !== 8'd0 || m_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_payload: busy=%b tready=%b pkt_len=%0d tvalid=%b expected 0 1 0 0",
                     busy, s_tready, pkt_len, m_tvalid);
        end
        idle(1);
        rst = 1'b0;
        run_std_packet("after_rst_payload");

        clear_mon();
        m_tready = 1'b0;
        load_std(8'h2E);
        send_frame();
        idle(1);
        vectors++;
        if (m_tvalid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_drain_pre: tvalid=%b busy=%b expected 1 1", m_tvalid, busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({m_tvalid, m_tlast, m_tdata, pkt_len, busy, s_tready}
            !== {1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_drain: tvalid=%b tlast=%b tdata=%h pkt_len=%0d busy=%b tready=%b expected 0 0 0000 0 0 1",
                     m_tvalid, m_tlast, m_tdata, pkt_len, busy, s_tready);
        end
        idle(1);
        rst = 1'b0;
        run_std_packet("after_rst_drain");
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_checksum();
        test_length_errors();
        test_timeout();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
